// File: rtl/distance_echo.sv
// rtl/distance_echo.sv - ultrasonic echo receiver: times the echo pulse and reports whole centimetres; optional DISTANCE_AVG_EN averages the last 4 results
module distance_echo #(
   parameter int CYC_PER_CM   = 7250,
   parameter int MAX_CM       = 400,
   parameter int ARM_TIMEOUT  = 125000,
   parameter int ECHO_TIMEOUT = 3000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       trig_sig,
   input  logic       echo,
   output logic [9:0] distance,
   output logic       dist_valid,
   output logic       timeout,
   output logic       busy
);

   localparam logic [21:0] ARM_LAST  = 22'(ARM_TIMEOUT - 1);
   localparam logic [21:0] ECHO_LAST = 22'(ECHO_TIMEOUT - 1);
   localparam logic [12:0] PRE_LAST  = 13'(CYC_PER_CM - 1);
   localparam logic [9:0]  CM_MAX    = 10'(MAX_CM);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_MEASURE} state_t;

   state_t      state_q, state_d;
   logic        echo_meta_q, echo_s_q, echo_s_prev_q, trig_prev_q;
   logic [21:0] wait_cnt_q, wait_cnt_d;
   logic [12:0] pre_cnt_q, pre_cnt_d;
   logic [9:0]  cm_cnt_q, cm_cnt_d;
   logic        timeout_q, timeout_d;
   logic        res_valid_d;
   logic        count_en;
   logic [9:0]  distance_q;
   logic        dist_valid_q;
   logic        trig_fall, echo_rise, echo_fall;

   assign trig_fall = trig_prev_q & ~trig_sig;
   assign echo_rise = echo_s_q & ~echo_s_prev_q;
   assign echo_fall = ~echo_s_q & echo_s_prev_q;

   // Echo synchronizer plus the delayed copies used for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         echo_meta_q   <= 1'b0;
         echo_s_q      <= 1'b0;
         echo_s_prev_q <= 1'b0;
         trig_prev_q   <= 1'b0;
      end else begin
         echo_meta_q   <= echo;
         echo_s_q      <= echo_meta_q;
         echo_s_prev_q <= echo_s_q;
         trig_prev_q   <= trig_sig;
      end
   end

   // State register with the timing counters and the timeout strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         wait_cnt_q <= '0;
         pre_cnt_q  <= '0;
         cm_cnt_q   <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         pre_cnt_q  <= pre_cnt_d;
         cm_cnt_q   <= cm_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   // Next state and counter updates; a trigger fall always wins over timeouts
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      pre_cnt_d   = pre_cnt_q;
      cm_cnt_d    = cm_cnt_q;
      timeout_d   = 1'b0;
      res_valid_d = 1'b0;
      count_en    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (trig_fall) begin
               state_d    = S_ARMED;
               wait_cnt_d = '0;
               pre_cnt_d  = '0;
               cm_cnt_d   = '0;
            end
         end
         S_ARMED: begin
            if (trig_fall) begin
               wait_cnt_d = '0;
               pre_cnt_d  = '0;
               cm_cnt_d   = '0;
            end else if (echo_rise) begin
               // The rise cycle is itself echo-high time, so it is counted here
               state_d    = S_MEASURE;
               wait_cnt_d = '0;
               count_en   = 1'b1;
            end else if (wait_cnt_q == ARM_LAST) begin
               state_d   = S_IDLE;
               timeout_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 22'd1;
            end
         end
         S_MEASURE: begin
            if (trig_fall) begin
               state_d    = S_ARMED;
               wait_cnt_d = '0;
               pre_cnt_d  = '0;
               cm_cnt_d   = '0;
            end else if (echo_fall) begin
               state_d     = S_IDLE;
               res_valid_d = 1'b1;
            end else if (wait_cnt_q == ECHO_LAST && echo_s_q) begin
               state_d   = S_IDLE;
               timeout_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 22'd1;
               count_en   = echo_s_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (count_en) begin
         if (pre_cnt_q == PRE_LAST) begin
            pre_cnt_d = '0;
            if (cm_cnt_q != CM_MAX) begin
               cm_cnt_d = cm_cnt_q + 10'd1;
            end
         end else begin
            pre_cnt_d = pre_cnt_q + 13'd1;
         end
      end
   end

   // Outputs decoded from the current state
   always_comb begin
      busy = (state_q != S_IDLE);
   end

`ifdef DISTANCE_AVG_EN
   logic [9:0]  hist_q [4];
   logic        avg_pend_q;
   logic [11:0] sum;

   assign sum = 12'(hist_q[0]) + 12'(hist_q[1]) + 12'(hist_q[2]) + 12'(hist_q[3]);

   // Four-deep result history; the average is published one cycle after a new entry
   always_ff @(posedge clk) begin
      if (rst) begin
         hist_q[0]    <= '0;
         hist_q[1]    <= '0;
         hist_q[2]    <= '0;
         hist_q[3]    <= '0;
         avg_pend_q   <= 1'b0;
         distance_q   <= '0;
         dist_valid_q <= 1'b0;
      end else begin
         avg_pend_q   <= res_valid_d;
         dist_valid_q <= avg_pend_q;
         if (res_valid_d) begin
            hist_q[0] <= cm_cnt_q;
            hist_q[1] <= hist_q[0];
            hist_q[2] <= hist_q[1];
            hist_q[3] <= hist_q[2];
         end
         if (avg_pend_q) begin
            distance_q <= 10'(sum >> 2);
         end
      end
   end
`else
   // Raw result register, loaded when the echo falls
   always_ff @(posedge clk) begin
      if (rst) begin
         distance_q   <= '0;
         dist_valid_q <= 1'b0;
      end else begin
         dist_valid_q <= res_valid_d;
         if (res_valid_d) begin
            distance_q <= cm_cnt_q;
         end
      end
   end
`endif

   assign distance   = distance_q;
   assign dist_valid = dist_valid_q;
   assign timeout    = timeout_q;

endmodule

// File: tb/tb_distance_echo.sv
// tb/tb_distance_echo.sv - randomized directed bench for distance_echo against a centimetre model
module tb_distance_echo;

   localparam int CPC  = 8;
   localparam int MCM  = 20;
   localparam int ARMT = 100;
   localparam int ECHT = 300;

   logic       clk = 1'b0;
   logic       rst;
   logic       trig_sig;
   logic       echo;
   logic [9:0] distance;
   logic       dist_valid;
   logic       timeout;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int nvalid = 0;
   int ntmo = 0;
   int cyc = 0;
   int busy_rise_cyc = 0;
   int tmo_cyc = 0;
   int both_hi = 0;
   logic busy_prev = 1'b0;
   int model_dist = 0;
   int hist[$] = '{0, 0, 0, 0};

   distance_echo #(
      .CYC_PER_CM(CPC),
      .MAX_CM(MCM),
      .ARM_TIMEOUT(ARMT),
      .ECHO_TIMEOUT(ECHT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .trig_sig(trig_sig),
      .echo(echo),
      .distance(distance),
      .dist_valid(dist_valid),
      .timeout(timeout),
      .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc++;
      if (dist_valid === 1'b1) nvalid++;
      if (timeout === 1'b1) begin
         ntmo++;
         tmo_cyc = cyc;
      end
      if (dist_valid === 1'b1 && timeout === 1'b1) both_hi++;
      if (busy === 1'b1 && busy_prev !== 1'b1) busy_rise_cyc = cyc;
      busy_prev = busy;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_trig();
      trig_sig = 1'b1;
      ticks(2);
      trig_sig = 1'b0;
      ticks(1);
   endtask

   task automatic model_reset();
      hist = '{0, 0, 0, 0};
      model_dist = 0;
   endtask

   task automatic model_result(input int width);
      int cm;
      cm = width / CPC;
      if (cm > MCM) cm = MCM;
`ifdef DISTANCE_AVG_EN
      hist.push_front(cm);
      void'(hist.pop_back());
      model_dist = (hist[0] + hist[1] + hist[2] + hist[3]) / 4;
`else
      model_dist = cm;
`endif
   endtask

   task automatic measure(input int width, input string tag);
      int v0, t0;
      v0 = nvalid;
      t0 = ntmo;
      pulse_trig();
      ticks($urandom_range(40, 1));
      echo = 1'b1;
      ticks(width);
      echo = 1'b0;
      ticks(12);
      model_result(width);
      check({tag, "_valid_count"}, nvalid - v0, 1);
      check({tag, "_timeout_count"}, ntmo - t0, 0);
      check({tag, "_distance"}, 32'(distance), model_dist);
      check({tag, "_busy"}, 32'(busy), 0);
   endtask

   initial begin
      int v0, t0, w;
      rst = 1'b1;
      trig_sig = 1'b0;
      echo = 1'b0;
      ticks(3);
      check("reset_distance", 32'(distance), 0);
      check("reset_valid", 32'(dist_valid), 0);
      check("reset_timeout", 32'(timeout), 0);
      check("reset_busy", 32'(busy), 0);
      rst = 1'b0;
      ticks(2);

      measure(10 * CPC, "exact_10cm");
      measure(10 * CPC - 1, "just_below_10cm");
      measure(250, "saturated");
      measure(CPC, "one_cm");
      measure(CPC - 1, "zero_cm");

      for (int i = 0; i < 6; i++) begin
         w = $urandom_range(290, 1);
         measure(w, $sformatf("random_%0d_w%0d", i, w));
      end

      v0 = nvalid;
      t0 = ntmo;
      pulse_trig();
      ticks(ARMT + 10);
      check("arm_timeout_count", ntmo - t0, 1);
      check("arm_timeout_no_valid", nvalid - v0, 0);
      check("arm_timeout_latency", tmo_cyc - busy_rise_cyc, ARMT);
      check("arm_timeout_distance_kept", 32'(distance), model_dist);
      check("arm_timeout_busy", 32'(busy), 0);

      v0 = nvalid;
      t0 = ntmo;
      pulse_trig();
      ticks(5);
      echo = 1'b1;
      ticks(ECHT + 40);
      echo = 1'b0;
      ticks(10);
      check("echo_stuck_timeout", ntmo - t0, 1);
      check("echo_stuck_no_valid", nvalid - v0, 0);
      check("echo_stuck_distance_kept", 32'(distance), model_dist);

      v0 = nvalid;
      t0 = ntmo;
      echo = 1'b1;
      ticks(5);
      pulse_trig();
      ticks(ARMT + 10);
      check("prehigh_timeout", ntmo - t0, 1);
      check("prehigh_no_valid", nvalid - v0, 0);
      echo = 1'b0;
      ticks(5);

      v0 = nvalid;
      t0 = ntmo;
      pulse_trig();
      ticks(5);
      echo = 1'b1;
      ticks(50);
      pulse_trig();
      echo = 1'b0;
      ticks(5);
      echo = 1'b1;
      ticks(120);
      echo = 1'b0;
      ticks(12);
      model_result(120);
      check("retrig_valid_count", nvalid - v0, 1);
      check("retrig_timeout_count", ntmo - t0, 0);
      check("retrig_distance", 32'(distance), model_dist);

      pulse_trig();
      ticks(5);
      echo = 1'b1;
      ticks(30);
      rst = 1'b1;
      ticks(1);
      check("midrst_distance", 32'(distance), 0);
      check("midrst_busy", 32'(busy), 0);
      check("midrst_valid", 32'(dist_valid), 0);
      check("midrst_timeout", 32'(timeout), 0);
      rst = 1'b0;
      echo = 1'b0;
      model_reset();
      ticks(5);
      measure(12 * CPC, "after_reset");

      check("valid_timeout_exclusive", both_hi, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
